// File: rtl/sde_ps_rd_pack_if.sv
// PCIS read-packer bundle: request side, R channel and slave word port.
// master = the packer, slave = PS FSM / PCIS sink / word slave side.
interface sde_ps_rd_pack_if #(
  parameter int PCIS_DATA_WIDTH = 512,
  parameter int PCIS_ADDR_WIDTH = 64,
  parameter int ACC_WIDTH       = 64
);
  logic                       pcis_req_rd;
  logic [PCIS_ADDR_WIDTH-1:0] pcis_req_addr;
  logic [7:0]                 pcis_req_len;
  logic                       pcis_req_busy;
  logic                       pcis_req_done;
  logic [PCIS_DATA_WIDTH-1:0] pcis_rdata;
  logic                       pcis_rlast;
  logic                       pcis_rvalid;
  logic                       pcis_rready;
  logic                       acc_rd_req;
  logic [PCIS_ADDR_WIDTH-1:0] acc_rd_addr;
  logic [ACC_WIDTH-1:0]       acc_rdata;
  logic                       acc_ack;
  logic                       unalin_error;

  modport master (
    input  pcis_req_rd, pcis_req_addr, pcis_req_len, pcis_rready, acc_rdata, acc_ack,
    output pcis_req_busy, pcis_req_done, pcis_rdata, pcis_rlast, pcis_rvalid,
    output acc_rd_req, acc_rd_addr, unalin_error
  );

  modport slave (
    output pcis_req_rd, pcis_req_addr, pcis_req_len, pcis_rready, acc_rdata, acc_ack,
    input  pcis_req_busy, pcis_req_done, pcis_rdata, pcis_rlast, pcis_rvalid,
    input  acc_rd_req, acc_rd_addr, unalin_error
  );
endinterface

// File: rtl/sde_ps_rd_pack.sv
// PCIS read packer: fetches ACC_WIDTH words from a req/ack slave and packs them into PCIS beats.
// First rvalid WPB+1 cycles after request with ack tied high; two beats buffered, fetch stalls when both are full.
module sde_ps_rd_pack #(
  parameter int PCIS_DATA_WIDTH = 512,
  parameter int PCIS_ADDR_WIDTH = 64,
  parameter int ACC_WIDTH       = 64,
  parameter int WPB             = PCIS_DATA_WIDTH / ACC_WIDTH
) (
  input logic            clk,
  input logic            rst_n,
  sde_ps_rd_pack_if.master bus
);
  localparam int IDXW = (WPB > 1) ? $clog2(WPB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WPB - 1);
  localparam logic [PCIS_ADDR_WIDTH-1:0] ADDR_STEP = PCIS_ADDR_WIDTH'(ACC_WIDTH / 8);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                     state;
  logic [PCIS_ADDR_WIDTH-1:0] addr;
  logic [8:0]                 beats_left;
  logic [IDXW-1:0]            word_idx;
  logic [PCIS_DATA_WIDTH-1:0] asm_dat;
  logic                       asm_full;
  logic [PCIS_DATA_WIDTH-1:0] hold_dat;
  logic                       hold_vld;
  logic                       hold_last;
  logic                       busy;
  logic                       done;
  logic                       unalin;

  logic                       hold_free;
  logic                       rd_req;
  logic                       word_in;
  logic                       completing;
  logic                       asm_cmp;
  logic                       xfer;
  logic [PCIS_DATA_WIDTH-1:0] asm_next;

  // A complete assembly waits in asm_dat only when the hold register cannot take it.
  always_comb begin
    hold_free  = ~hold_vld | bus.pcis_rready;
    rd_req     = (state == FETCH) & ~(asm_full & ~hold_free);
    word_in    = rd_req & bus.acc_ack;
    completing = word_in & (word_idx == LAST_IDX);
    asm_cmp    = asm_full | completing;
    xfer       = asm_cmp & hold_free;
    asm_next   = asm_dat;
    if (word_in) begin
      asm_next[int'(word_idx)*ACC_WIDTH +: ACC_WIDTH] = bus.acc_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr       <= '0;
      beats_left <= '0;
      word_idx   <= '0;
      asm_dat    <= '0;
      asm_full   <= 1'b0;
      hold_dat   <= '0;
      hold_vld   <= 1'b0;
      hold_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      unalin     <= 1'b0;
    end else begin
      done   <= 1'b0;
      unalin <= 1'b0;

      if (word_in) begin
        asm_dat <= asm_next;
      end
      asm_full <= asm_cmp & ~xfer;

      // A beat waiting in asm_dat is the older one; otherwise the word arriving now completes it.
      if (xfer) begin
        hold_dat   <= asm_full ? asm_dat : asm_next;
        hold_last  <= (beats_left == 9'd1);
        hold_vld   <= 1'b1;
        beats_left <= beats_left - 9'd1;
      end else if (hold_vld && bus.pcis_rready) begin
        hold_vld  <= 1'b0;
        hold_last <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (bus.pcis_req_rd) begin
            addr       <= {bus.pcis_req_addr[PCIS_ADDR_WIDTH-1:6], 6'b0};
            beats_left <= {1'b0, bus.pcis_req_len} + 9'd1;
            word_idx   <= '0;
            busy       <= 1'b1;
            unalin     <= |bus.pcis_req_addr[5:0];
            state      <= FETCH;
          end
        end
        FETCH: begin
          if (word_in) begin
            addr     <= addr + ADDR_STEP;
            word_idx <= completing ? '0 : word_idx + 1'b1;
          end
          if (completing && beats_left == 9'd1) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (hold_vld && bus.pcis_rready && hold_last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pcis_req_busy = busy;
  assign bus.pcis_req_done = done;
  assign bus.pcis_rdata    = hold_dat;
  assign bus.pcis_rlast    = hold_last;
  assign bus.pcis_rvalid   = hold_vld;
  assign bus.acc_rd_req    = rd_req;
  assign bus.acc_rd_addr   = addr;
  assign bus.unalin_error  = unalin;
endmodule

// File: tb/tb_sde_ps_rd_pack.sv
// Scoreboard bench for sde_ps_rd_pack: expected addresses and beats are queued at request time.
module tb_sde_ps_rd_pack;
  localparam int DW  = 512;
  localparam int AW  = 64;
  localparam int ACW = 64;
  localparam int WPB = DW / ACW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sde_ps_rd_pack_if #(.PCIS_DATA_WIDTH(DW), .PCIS_ADDR_WIDTH(AW), .ACC_WIDTH(ACW)) bus ();

  sde_ps_rd_pack #(.PCIS_DATA_WIDTH(DW), .PCIS_ADDR_WIDTH(AW), .ACC_WIDTH(ACW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Slave: word at byte address A holds A/8+1; ack is either a level or a repeating 1,0,0,1 pattern.
  logic       ack_en = 1'b1;
  logic       stall_mode = 1'b0;
  logic [3:0] ack_pat = 4'b1001;
  int         cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  assign bus.acc_ack   = stall_mode ? ack_pat[cyc[1:0]] : ack_en;
  assign bus.acc_rdata = (bus.acc_rd_addr >> 3) + 64'd1;

  logic [DW-1:0] exp_dat_q[$];
  bit            exp_last_q[$];
  logic [AW-1:0] exp_addr_q[$];

  int            word_cnt = 0;
  int            beat_cnt = 0;
  int            done_cnt = 0;
  int            unalin_cnt = 0;
  logic [AW-1:0] last_ack_addr = '0;

  function automatic logic [DW-1:0] exp_beat(input logic [AW-1:0] base, input int b);
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    d = '0;
    for (int w = 0; w < WPB; w++) begin
      a = base + AW'((b * WPB + w) * (ACW / 8));
      d[w*ACW +: ACW] = ACW'((a >> 3) + 64'd1);
    end
    return d;
  endfunction

  task automatic push_req(input logic [AW-1:0] addr, input int len);
    logic [AW-1:0] base;
    base = {addr[AW-1:6], 6'b0};
    for (int b = 0; b <= len; b++) begin
      exp_dat_q.push_back(exp_beat(base, b));
      exp_last_q.push_back(b == len);
    end
    for (int k = 0; k < (len + 1) * WPB; k++) begin
      exp_addr_q.push_back(base + AW'(k * (ACW / 8)));
    end
  endtask

  task automatic issue_req(input logic [AW-1:0] addr, input int len, input bit expect_accept);
    @(posedge clk); #1;
    bus.pcis_req_rd   = 1'b1;
    bus.pcis_req_addr = addr;
    bus.pcis_req_len  = 8'(len);
    if (expect_accept) push_req(addr, len);
    @(posedge clk); #1;
    bus.pcis_req_rd = 1'b0;
  endtask

  task automatic wait_done(input int start, input int maxc, input string name);
    int n;
    n = 0;
    while (done_cnt == start && n < maxc) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (done_cnt == start) begin
      errors++;
      $display("FAIL %s_timeout: no pcis_req_done within %0d cycles", name, maxc);
    end
  endtask

  // Monitor: slave addresses, R-channel beats and stability under back-pressure.
  initial begin
    logic          prev_stall, prev_hold, prev_last, ea_last;
    logic [AW-1:0] prev_addr, ea;
    logic [DW-1:0] prev_dat, ed;
    prev_stall = 1'b0; prev_hold = 1'b0; prev_last = 1'b0;
    prev_addr = '0; prev_dat = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        prev_hold  = 1'b0;
      end else begin
        if (bus.pcis_req_done) done_cnt++;
        if (bus.unalin_error) unalin_cnt++;
        if (prev_stall && bus.acc_rd_req) begin
          checks++;
          if (bus.acc_rd_addr !== prev_addr) begin
            errors++;
            $display("FAIL addr_hold: got %h want %h", bus.acc_rd_addr, prev_addr);
          end
        end
        if (prev_hold) begin
          checks++;
          if (bus.pcis_rvalid !== 1'b1 || bus.pcis_rdata !== prev_dat || bus.pcis_rlast !== prev_last) begin
            errors++;
            $display("FAIL r_stable: rvalid=%b rlast=%b want rlast=%b data %h want %h",
                     bus.pcis_rvalid, bus.pcis_rlast, prev_last, bus.pcis_rdata, prev_dat);
          end
        end
        if (bus.acc_rd_req && bus.acc_ack) begin
          word_cnt++;
          last_ack_addr = bus.acc_rd_addr;
          checks++;
          if (exp_addr_q.size() == 0) begin
            errors++;
            $display("FAIL word_addr: unexpected word at %h, want none", bus.acc_rd_addr);
          end else begin
            ea = exp_addr_q.pop_front();
            if (bus.acc_rd_addr !== ea) begin
              errors++;
              $display("FAIL word_addr: got %h want %h", bus.acc_rd_addr, ea);
            end
          end
        end
        if (bus.pcis_rvalid && bus.pcis_rready) begin
          beat_cnt++;
          checks++;
          if (exp_dat_q.size() == 0) begin
            errors++;
            $display("FAIL beat: unexpected beat %h, want none", bus.pcis_rdata);
          end else begin
            ed = exp_dat_q.pop_front();
            ea_last = exp_last_q.pop_front();
            if (bus.pcis_rdata !== ed || bus.pcis_rlast !== ea_last) begin
              errors++;
              $display("FAIL beat: rlast=%b want %b data %h want %h", bus.pcis_rlast, ea_last, bus.pcis_rdata, ed);
            end
          end
        end
        prev_stall = bus.acc_rd_req & ~bus.acc_ack;
        prev_addr  = bus.acc_rd_addr;
        prev_hold  = bus.pcis_rvalid & ~bus.pcis_rready;
        prev_dat   = bus.pcis_rdata;
        prev_last  = bus.pcis_rlast;
      end
    end
  end

  task automatic test_reset();
    bus.pcis_req_rd = 1'b0; bus.pcis_req_addr = '0; bus.pcis_req_len = '0; bus.pcis_rready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.pcis_req_busy, bus.pcis_req_done, bus.pcis_rvalid, bus.pcis_rlast, bus.acc_rd_req, bus.unalin_error} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: busy/done/rvalid/rlast/req/unalin=%b want 000000",
               {bus.pcis_req_busy, bus.pcis_req_done, bus.pcis_rvalid, bus.pcis_rlast, bus.acc_rd_req, bus.unalin_error});
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.acc_rd_req !== 1'b0 || bus.pcis_req_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: req=%b busy=%b want 0 0", bus.acc_rd_req, bus.pcis_req_busy);
    end
  endtask

  task automatic test_single_beat();
    int lat, w0, b0, u0;
    logic [DW-1:0] want;
    logic [AW-1:0] zero_addr;
    want = '0;
    for (int w = 0; w < WPB; w++) want[w*ACW +: ACW] = ACW'(w + 1);
    zero_addr = '0;
    w0 = word_cnt; b0 = beat_cnt; u0 = unalin_cnt;
    ack_en = 1'b1; bus.pcis_rready = 1'b1;
    issue_req(zero_addr, 0, 1'b1);
    lat = 1;
    while (!bus.pcis_rvalid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != WPB + 1) begin errors++; $display("FAIL single_latency: got %0d want %0d", lat, WPB + 1); end
    checks++;
    if (bus.pcis_rdata !== want || bus.pcis_rlast !== 1'b1) begin
      errors++;
      $display("FAIL single_data: rlast=%b data %h want rlast=1 data %h", bus.pcis_rlast, bus.pcis_rdata, want);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.pcis_req_done !== 1'b1 || bus.pcis_req_busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done: done=%b busy=%b want 1 0", bus.pcis_req_done, bus.pcis_req_busy);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.pcis_req_done !== 1'b0) begin errors++; $display("FAIL single_done_pulse: done=%b want 0", bus.pcis_req_done); end
    checks++;
    if (word_cnt - w0 != WPB || beat_cnt - b0 != 1 || unalin_cnt != u0) begin
      errors++;
      $display("FAIL single_counts: words=%0d beats=%0d unalin=%0d want %0d 1 0", word_cnt - w0, beat_cnt - b0, unalin_cnt - u0, WPB);
    end
  endtask

  task automatic test_back_pressure();
    int w0, b0, d0;
    logic [AW-1:0] base;
    base = 64'h2000;
    w0 = word_cnt; b0 = beat_cnt; d0 = done_cnt;
    bus.pcis_rready = 1'b0;
    issue_req(base, 3, 1'b1);
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (bus.acc_rd_req !== 1'b0 || word_cnt - w0 != 2 * WPB) begin
      errors++;
      $display("FAIL bp_stall: req=%b words=%0d want 0 %0d", bus.acc_rd_req, word_cnt - w0, 2 * WPB);
    end
    checks++;
    if (bus.pcis_rvalid !== 1'b1 || bus.pcis_rlast !== 1'b0 || bus.pcis_rdata !== exp_beat(base, 0)) begin
      errors++;
      $display("FAIL bp_hold: rvalid=%b rlast=%b data %h want 1 0 %h", bus.pcis_rvalid, bus.pcis_rlast, bus.pcis_rdata, exp_beat(base, 0));
    end
    bus.pcis_rready = 1'b1;
    wait_done(d0, 200, "bp");
    checks++;
    if (word_cnt - w0 != 4 * WPB || beat_cnt - b0 != 4) begin
      errors++;
      $display("FAIL bp_counts: words=%0d beats=%0d want %0d 4", word_cnt - w0, beat_cnt - b0, 4 * WPB);
    end
  endtask

  task automatic test_slave_stall();
    int w0, b0, d0;
    w0 = word_cnt; b0 = beat_cnt; d0 = done_cnt;
    bus.pcis_rready = 1'b1;
    stall_mode = 1'b1;
    issue_req(64'h1000, 1, 1'b1);
    wait_done(d0, 300, "stall");
    stall_mode = 1'b0;
    checks++;
    if (last_ack_addr !== 64'h1078 || word_cnt - w0 != 2 * WPB || beat_cnt - b0 != 2) begin
      errors++;
      $display("FAIL stall_end: last_addr=%h words=%0d beats=%0d want 1078 %0d 2", last_ack_addr, word_cnt - w0, beat_cnt - b0, 2 * WPB);
    end
  endtask

  task automatic test_unaligned();
    int u0, d0;
    u0 = unalin_cnt; d0 = done_cnt;
    bus.pcis_rready = 1'b1;
    issue_req(64'h1004, 0, 1'b1);
    checks++;
    if (bus.unalin_error !== 1'b1) begin errors++; $display("FAIL unalin_pulse: got %b want 1", bus.unalin_error); end
    wait_done(d0, 100, "unalin");
    checks++;
    if (unalin_cnt - u0 != 1) begin errors++; $display("FAIL unalin_count: got %0d want 1", unalin_cnt - u0); end
  endtask

  task automatic test_busy_reject();
    int b0, d0;
    b0 = beat_cnt; d0 = done_cnt;
    bus.pcis_rready = 1'b1;
    issue_req(64'h3000, 1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.pcis_req_busy !== 1'b1) begin errors++; $display("FAIL busy_set: got %b want 1", bus.pcis_req_busy); end
    issue_req(64'h5000, 0, 1'b0);
    wait_done(d0, 200, "busy");
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (beat_cnt - b0 != 2 || done_cnt - d0 != 1 || bus.pcis_req_busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_reject: beats=%0d dones=%0d busy=%b want 2 1 0", beat_cnt - b0, done_cnt - d0, bus.pcis_req_busy);
    end
  endtask

  task automatic test_reset_mid();
    int b0, d0;
    d0 = done_cnt;
    bus.pcis_rready = 1'b0;
    issue_req(64'h6000, 3, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (bus.pcis_rvalid !== 1'b1 || bus.acc_rd_req !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: rvalid=%b req=%b want 1 1", bus.pcis_rvalid, bus.acc_rd_req);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.pcis_rvalid !== 1'b0 || bus.acc_rd_req !== 1'b0 || bus.pcis_req_busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: rvalid=%b req=%b busy=%b want 0 0 0", bus.pcis_rvalid, bus.acc_rd_req, bus.pcis_req_busy);
    end
    exp_dat_q.delete();
    exp_last_q.delete();
    exp_addr_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if (done_cnt != d0) begin errors++; $display("FAIL rstmid_nodone: dones=%0d want 0", done_cnt - d0); end
    b0 = beat_cnt; d0 = done_cnt;
    bus.pcis_rready = 1'b1;
    issue_req(64'h7000, 0, 1'b1);
    wait_done(d0, 100, "rstmid");
    checks++;
    if (beat_cnt - b0 != 1) begin errors++; $display("FAIL rstmid_after: beats=%0d want 1", beat_cnt - b0); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_beat();
    test_back_pressure();
    test_slave_stall();
    test_unaligned();
    test_busy_reject();
    test_reset_mid();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_dat_q.size() != 0 || exp_addr_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: beats=%0d words=%0d want 0 0", exp_dat_q.size(), exp_addr_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
